// File: rtl/jar_sram_pkg.sv
// Shared definitions for the nibble-serial SRAM host controller.
// Op codes, pin bit positions and the host FSM state type.
package jar_sram_pkg;

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_STREAM = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam int PIN_CLK    = 0;
    localparam int PIN_WE     = 1;
    localparam int PIN_OE     = 2;
    localparam int PIN_COMMIT = 3;
    localparam int PIN_NIB    = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        WR_COMMIT,
        RD_ADDR,
        ST_START,
        ST_DATA
    } state_e;

    // Device clock bit is left 0 here; the tick generator supplies it.
    function automatic logic [7:0] mk_pins(
        input logic       we,
        input logic       oe,
        input logic       cm,
        input logic [3:0] nib
    );
        logic [7:0] p;
        p             = '0;
        p[PIN_WE]     = we;
        p[PIN_OE]     = oe;
        p[PIN_COMMIT] = cm;
        p[PIN_NIB+:4] = nib;
        return p;
    endfunction

endpackage

// File: rtl/jar_sram_tick_gen.sv
// Device clock phase counter: one tick is CLK_DIV low cycles then
// CLK_DIV high cycles, with strobes on the first and last cycle.
module jar_sram_tick_gen
    import jar_sram_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic dclk,
    output logic tick_start,
    output logic tick_end
);

    localparam int CW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q;
    logic          dclk_q, dclk_d;

    // `run` is the next-cycle activity, so a fresh operation starts at 0.
    always_comb begin
        cnt_d = '0;
        if (run && run_q && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
        dclk_d = run && (cnt_d >= HALF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            dclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run;
            dclk_q <= dclk_d;
        end
    end

    assign dclk       = dclk_q;
    assign tick_start = run_q && (cnt_q == '0);
    assign tick_end   = run_q && (cnt_q == LAST);

endmodule

// File: rtl/jar_sram_host.sv
// Host-side initiator for the 8-pin nibble-serial SRAM device:
// request FSM, captured request fields, pin drive and responses.
module jar_sram_host
    import jar_sram_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [3:0] req_len,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic [7:0] sram_io_in,
    input  logic [7:0] sram_io_out
);

    state_e     state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] rem_q, rem_d;
    logic [7:0] pins_q, pins_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_last_q, rsp_last_d;

    logic run;
    logic dclk;
    logic tick_start;
    logic tick_end;

    jar_sram_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .dclk      (dclk),
        .tick_start(tick_start),
        .tick_end  (tick_end)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rem_d       = rem_q;
        pins_d      = pins_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 8'h00;
        rsp_last_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rem_d   = req_len;
                    unique case (req_op)
                        OP_WRITE: begin
                            state_d = WR_LO;
                            pins_d  = mk_pins(1'b1, 1'b0, 1'b0, req_wdata[3:0]);
                        end
                        OP_READ: begin
                            state_d = RD_ADDR;
                            pins_d  = mk_pins(1'b0, 1'b1, 1'b0, {1'b0, req_addr});
                        end
                        OP_STREAM: begin
                            state_d = ST_START;
                            pins_d  = mk_pins(1'b1, 1'b1, 1'b1, {1'b0, req_addr});
                        end
                        default: ;
                    endcase
                end
            end
            WR_LO: begin
                if (tick_end) begin
                    state_d = WR_HI;
                    pins_d  = mk_pins(1'b1, 1'b0, 1'b0, wdata_q[7:4]);
                end
            end
            WR_HI: begin
                if (tick_end) begin
                    state_d = WR_COMMIT;
                    pins_d  = mk_pins(1'b0, 1'b0, 1'b1, {1'b0, addr_q});
                end
            end
            WR_COMMIT: begin
                if (tick_end) begin
                    state_d     = IDLE;
                    pins_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                end
            end
            RD_ADDR: begin
                if (tick_end) begin
                    state_d     = IDLE;
                    pins_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sram_io_out;
                    rsp_last_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tick_end) begin
                    state_d = ST_DATA;
                    pins_d  = mk_pins(1'b1, 1'b1, 1'b0, 4'h0);
                end
            end
            ST_DATA: begin
                // rem counts the bytes still owed after this one
                if (tick_end) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = sram_io_out;
                    if (rem_q == 4'd0) begin
                        state_d    = IDLE;
                        pins_d     = '0;
                        rsp_last_d = 1'b1;
                    end else begin
                        rem_d = rem_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pins_d  = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    assign run = (state_d != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rem_q       <= '0;
            pins_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rem_q       <= rem_d;
            pins_q      <= pins_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    logic unused_tick_start;
    assign unused_tick_start = tick_start;

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign sram_io_in = pins_q | {7'b0, dclk};

endmodule

// File: tb/tb_jar_sram_host.sv
// Directed bench for jar_sram_host with a behavioral nibble-serial
// SRAM device model attached to the pin bus.
module tb_jar_sram_host;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] req_len;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic [7:0] sram_io_in;
    logic [7:0] sram_io_out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    jar_sram_host #(
        .CLK_DIV(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_len    (req_len),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .sram_io_in (sram_io_in),
        .sram_io_out(sram_io_out)
    );

    // Behavioral device: acts on each rising edge of the device clock.
    logic [7:0] mem [8];
    logic [7:0] wbuf;
    logic [2:0] ptr;
    logic [7:0] dev_out;

    assign sram_io_out = dev_out;

    always @(posedge sram_io_in[0]) begin
        logic [3:0] nib;
        logic       we, oe, cm;
        nib = sram_io_in[7:4];
        we  = sram_io_in[1];
        oe  = sram_io_in[2];
        cm  = sram_io_in[3];
        if (we && oe && cm) begin
            ptr = nib[2:0];
        end else if (we && oe) begin
            dev_out = mem[ptr];
            ptr     = ptr + 3'd1;
        end else if (we) begin
            wbuf = {nib, wbuf[7:4]};
        end else if (cm) begin
            mem[nib[2:0]] = wbuf;
        end else if (oe) begin
            dev_out = mem[nib[2:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [2:0] a,
                         input logic [7:0] wd, input logic [3:0] ln,
                         input bit keep);
        int w;
        w         = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_len   = ln;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("issue_ready", {31'b0, req_ready}, 1);
        @(negedge clk);
        cyc = 1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int at,
                            output logic [7:0] d, output logic l,
                            output logic rdy);
        at  = -1;
        d   = 8'h00;
        l   = 1'b0;
        rdy = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (rsp_valid) begin
                at  = cyc;
                d   = rsp_data;
                l   = rsp_last;
                rdy = req_ready;
                tick();
                return;
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         at;
        logic [7:0] d;
        logic       l;
        logic       rdy;
        int         bad;
        logic [7:0] wr_base [3];
        int         st_cyc  [4];
        logic [7:0] st_dat  [4];

        wr_base = '{8'h52, 8'hA2, 8'h38};
        st_cyc  = '{9, 13, 17, 21};
        st_dat  = '{8'h16, 8'h17, 8'h10, 8'h11};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = 3'd0;
        req_wdata = 8'h00;
        req_len   = 4'd0;
        dev_out   = 8'h00;
        wbuf      = 8'h00;
        ptr       = 3'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, req_ready}, 0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check_eq("rst_rsp_data", {24'b0, rsp_data}, 0);
        check_eq("rst_rsp_last", {31'b0, rsp_last}, 0);
        check_eq("rst_io", {24'b0, sram_io_in}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", {31'b0, req_ready}, 1);

        // write 0xA5 to addr 3, pins checked every cycle of 3 ticks
        issue(2'd0, 3'd3, 8'hA5, 4'd0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            logic [7:0] e;
            e = wr_base[(c - 1) / 4];
            if (((c - 1) % 4) >= 2) e[0] = 1'b1;
            check_eq("wr_pins", {24'b0, sram_io_in}, {24'b0, e});
            tick();
        end
        wait_rsp(40, at, d, l, rdy);
        check_eq("wr_ack_cycle", at, 13);
        check_eq("wr_ack_data", {24'b0, d}, 0);
        check_eq("wr_ack_last", {31'b0, l}, 1);
        check_eq("wr_ack_ready", {31'b0, rdy}, 1);
        check_eq("wr_mem", {24'b0, mem[3]}, 32'hA5);

        // read addr 3
        mem[3] = 8'hA5;
        mem[4] = 8'h5A;
        issue(2'd1, 3'd3, 8'h00, 4'd0, 1'b0);
        check_eq("rd_pins", {24'b0, sram_io_in}, 32'h34);
        wait_rsp(40, at, d, l, rdy);
        check_eq("rd_cycle", at, 5);
        check_eq("rd_data", {24'b0, d}, 32'hA5);
        check_eq("rd_last", {31'b0, l}, 1);

        // stream of 4 from 6, wrapping past 7
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        issue(2'd2, 3'd6, 8'h00, 4'd3, 1'b0);
        check_eq("st_start_pins", {24'b0, sram_io_in}, 32'h6E);
        tick();
        tick();
        tick();
        tick();
        check_eq("st_data_pins", {24'b0, sram_io_in}, 32'h06);
        for (int i = 0; i < 4; i++) begin
            wait_rsp(40, at, d, l, rdy);
            check_eq("st_cycle", at, st_cyc[i]);
            check_eq("st_data", {24'b0, d}, {24'b0, st_dat[i]});
            check_eq("st_last", {31'b0, l}, (i == 3) ? 1 : 0);
        end
        check_eq("st_idle_io", {24'b0, sram_io_in}, 0);
        check_eq("st_idle_ready", {31'b0, req_ready}, 1);

        // single-byte stream
        issue(2'd2, 3'd5, 8'h00, 4'd0, 1'b0);
        wait_rsp(40, at, d, l, rdy);
        check_eq("st1_cycle", at, 9);
        check_eq("st1_data", {24'b0, d}, 32'h15);
        check_eq("st1_last", {31'b0, l}, 1);

        // reset during the second we tick aborts the write
        mem[5] = 8'h77;
        issue(2'd0, 3'd5, 8'h3C, 4'd0, 1'b0);
        while (cyc < 6) tick();
        rst_n = 1'b0;
        tick();
        check_eq("abort_io", {24'b0, sram_io_in}, 0);
        check_eq("abort_ready", {31'b0, req_ready}, 0);
        check_eq("abort_rsp", {31'b0, rsp_valid}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("abort_ready_back", {31'b0, req_ready}, 1);
        wait_rsp(20, at, d, l, rdy);
        check_eq("abort_no_rsp", at, -1);
        check_eq("abort_mem", {24'b0, mem[5]}, 32'h77);

        // write then read back-to-back with req_valid held
        issue(2'd0, 3'd2, 8'h5E, 4'd0, 1'b1);
        req_op   = 2'd1;
        req_addr = 3'd2;
        wait_rsp(40, at, d, l, rdy);
        req_valid = 1'b0;
        check_eq("b2b_wr_cycle", at, 13);
        check_eq("b2b_wr_ready", {31'b0, rdy}, 1);
        check_eq("b2b_rd_pins", {24'b0, sram_io_in}, 32'h24);
        wait_rsp(40, at, d, l, rdy);
        check_eq("b2b_rd_cycle", at, 18);
        check_eq("b2b_rd_data", {24'b0, d}, 32'h5E);

        // reserved op
        issue(2'd3, 3'd1, 8'hFF, 4'd0, 1'b0);
        check_eq("rsv_ready", {31'b0, req_ready}, 1);
        check_eq("rsv_io", {24'b0, sram_io_in}, 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid || sram_io_in != 8'h00 || !req_ready) bad++;
            tick();
        end
        check_eq("rsv_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
